// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: FSM state encoding and default sizing.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle count ticks; tick is high on the last cycle of each period.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // With PRESCALE=1 the count is pinned at 0, so tick reduces to enable.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (r_count == LAST) r_count <= '0;
      else                 r_count <= r_count + CW'(1);
    end
  end

  assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/up_counter_ctrl.sv
// Programmable up-counting timer with start/stop FSM, one-shot or auto-reload, tc pulse and done flag.
module up_counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_limit_q;
  logic             r_reload_q;
  logic             r_busy;
  logic             r_tc;
  logic             r_done;
  logic             w_tick;
  logic             w_pre_clear;
  logic             w_pre_enable;

  // Prescaler only runs in RUN; stop clears it in the same cycle so the discarded tick leaves no residue.
  assign w_pre_enable = (r_state == ST_RUN);
  assign w_pre_clear  = (r_state != ST_RUN) || stop;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_pre_clear),
    .enable (w_pre_enable),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_counter  <= '0;
      r_limit_q  <= '0;
      r_reload_q <= 1'b0;
      r_busy     <= 1'b0;
      r_tc       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_state    <= ST_RUN;
            r_counter  <= '0;
            r_limit_q  <= limit;
            r_reload_q <= auto_reload;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (r_counter != r_limit_q) begin
              r_counter <= r_counter + WIDTH'(1);
            end else begin
              r_tc <= 1'b1;
              if (r_reload_q) begin
                r_counter <= '0;
              end else begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else if (start) begin
            r_state    <= ST_RUN;
            r_counter  <= '0;
            r_limit_q  <= limit;
            r_reload_q <= auto_reload;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign counter = r_counter;
  assign busy    = r_busy;
  assign tc      = r_tc;
  assign done    = r_done;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed bench for up_counter_ctrl: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_up_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, stop_a, auto_a;
  logic [3:0] limit_a;
  logic [3:0] counter_a;
  logic       busy_a, tc_a, done_a;
  logic       start_b, stop_b, auto_b;
  logic [3:0] limit_b;
  logic [3:0] counter_b;
  logic       busy_b, tc_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  up_counter_ctrl #(.WIDTH(4), .PRESCALE(1)) dut_a (
    .clk (clk), .reset (reset), .start (start_a), .stop (stop_a),
    .auto_reload (auto_a), .limit (limit_a), .counter (counter_a),
    .busy (busy_a), .tc (tc_a), .done (done_a)
  );

  up_counter_ctrl #(.WIDTH(4), .PRESCALE(4)) dut_b (
    .clk (clk), .reset (reset), .start (start_b), .stop (stop_b),
    .auto_reload (auto_b), .limit (limit_b), .counter (counter_b),
    .busy (busy_b), .tc (tc_b), .done (done_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks counter/busy/tc/done of instance A in one line.
  task automatic chk_a(input string tag, input int c, input bit b, input bit t, input bit d);
    chk({tag, ".counter"}, 32'(counter_a), 32'(c));
    chk({tag, ".busy"},    32'(busy_a),    32'(b));
    chk({tag, ".tc"},      32'(tc_a),      32'(t));
    chk({tag, ".done"},    32'(done_a),    32'(d));
    $display("[%0t] %s: counter=%0d busy=%0b tc=%0b done=%0b", $time, tag, counter_a, busy_a, tc_a, done_a);
  endtask

  task automatic chk_b(input string tag, input int c, input bit b, input bit t, input bit d);
    chk({tag, ".counter"}, 32'(counter_b), 32'(c));
    chk({tag, ".busy"},    32'(busy_b),    32'(b));
    chk({tag, ".tc"},      32'(tc_b),      32'(t));
    chk({tag, ".done"},    32'(done_b),    32'(d));
    $display("[%0t] %s: counter=%0d busy=%0b tc=%0b done=%0b", $time, tag, counter_b, busy_b, tc_b, done_b);
  endtask

  initial begin
    int ar_cnt [9];
    bit ar_tc  [9];
    ar_cnt = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
    ar_tc  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

    reset = 1'b1;
    start_a = 0; stop_a = 0; auto_a = 0; limit_a = 0;
    start_b = 0; stop_b = 0; auto_b = 0; limit_b = 0;
    step(); step();
    reset = 1'b0;
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);

    // One-shot, limit=3
    start_a = 1; limit_a = 3; auto_a = 0;
    step(); chk_a("os_e0", 0, 1, 0, 0);
    start_a = 0; limit_a = 9;
    step(); chk_a("os_e1", 1, 1, 0, 0);
    step(); chk_a("os_e2", 2, 1, 0, 0);
    step(); chk_a("os_e3", 3, 1, 0, 0);
    step(); chk_a("os_e4", 3, 0, 1, 1);
    step(); chk_a("os_e5", 3, 0, 0, 1);

    // start+stop together in DONE goes to IDLE, then again in IDLE stays IDLE
    start_a = 1; stop_a = 1;
    step(); chk_a("done_startstop", 3, 0, 0, 0);
    step(); chk_a("idle_startstop", 3, 0, 0, 0);
    start_a = 0; stop_a = 0;
    step(); chk_a("idle_hold", 3, 0, 0, 0);

    // Auto-reload, limit=2
    start_a = 1; limit_a = 2; auto_a = 1;
    step(); chk_a("ar_start", 0, 1, 0, 0);
    start_a = 0; auto_a = 0;
    for (int i = 0; i < 9; i++) begin
      step(); chk_a($sformatf("ar_%0d", i), ar_cnt[i], 1, ar_tc[i], 0);
    end

    // start during RUN is ignored; the latched limit=2 auto-reload continues
    start_a = 1; limit_a = 7; auto_a = 0;
    step(); chk_a("run_start_ign1", 1, 1, 0, 0);
    step(); chk_a("run_start_ign2", 2, 1, 0, 0);
    step(); chk_a("run_start_ign3", 0, 1, 1, 0);
    start_a = 0;
    stop_a = 1;
    step(); chk_a("ar_stop", 0, 0, 0, 0);
    stop_a = 0;

    // Stop at counter=6
    start_a = 1; limit_a = 10; auto_a = 0;
    step(); chk_a("stop_start", 0, 1, 0, 0);
    start_a = 0;
    repeat (6) step();
    chk_a("stop_pre", 6, 1, 0, 0);
    stop_a = 1;
    step(); chk_a("stop_at6", 6, 0, 0, 0);
    stop_a = 0;
    step(); chk_a("stop_hold", 6, 0, 0, 0);

    // Reset mid-RUN at counter=5, held 3 cycles
    start_a = 1; limit_a = 9;
    step(); start_a = 0;
    repeat (5) step();
    chk_a("rst_pre", 5, 1, 0, 0);
    reset = 1;
    step(); chk_a("rst_edge1", 0, 0, 0, 0);
    step(); step();
    reset = 0;
    step(); chk_a("rst_after", 0, 0, 0, 0);

    // limit=15 one-shot: no wrap
    start_a = 1; limit_a = 15; auto_a = 0;
    step(); chk_a("l15_start", 0, 1, 0, 0);
    start_a = 0;
    for (int k = 1; k <= 15; k++) begin
      step(); chk_a($sformatf("l15_k%0d", k), k, 1, 0, 0);
    end
    step(); chk_a("l15_match", 15, 0, 1, 1);
    step(); chk_a("l15_after", 15, 0, 0, 1);
    stop_a = 1;
    step(); chk_a("l15_stop", 15, 0, 0, 0);
    stop_a = 0;

    // limit=0 one-shot: tc on first tick
    start_a = 1; limit_a = 0; auto_a = 0;
    step(); chk_a("l0_start", 0, 1, 0, 0);
    start_a = 0;
    step(); chk_a("l0_tick1", 0, 0, 1, 1);
    step(); chk_a("l0_after", 0, 0, 0, 1);

    // limit=0 auto-reload with PRESCALE=1: tc continuously high (restart from DONE)
    start_a = 1; limit_a = 0; auto_a = 1;
    step(); chk_a("l0ar_start", 0, 1, 0, 0);
    start_a = 0;
    step(); chk_a("l0ar_1", 0, 1, 1, 0);
    step(); chk_a("l0ar_2", 0, 1, 1, 0);
    stop_a = 1;
    step(); chk_a("l0ar_stop", 0, 0, 0, 0);
    stop_a = 0;

    // PRESCALE=4, limit=1 one-shot
    start_b = 1; limit_b = 1; auto_b = 0;
    step(); chk_b("p4_e0", 0, 1, 0, 0);
    start_b = 0;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e < 4)       chk_b($sformatf("p4_e%0d", e), 0, 1, 0, 0);
      else if (e < 8)  chk_b($sformatf("p4_e%0d", e), 1, 1, 0, 0);
      else if (e == 8) chk_b($sformatf("p4_e%0d", e), 1, 0, 1, 1);
      else             chk_b($sformatf("p4_e%0d", e), 1, 0, 0, 1);
    end

    // PRESCALE=4, limit=0 auto-reload: tc one cycle every 4
    start_b = 1; limit_b = 0; auto_b = 1;
    step(); chk_b("p4ar_start", 0, 1, 0, 0);
    start_b = 0;
    for (int e = 1; e <= 12; e++) begin
      step(); chk_b($sformatf("p4ar_e%0d", e), 0, 1, (e % 4 == 0) ? 1'b1 : 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
